// File: rtl/even_parity_rx.sv
`default_nettype none
// ============================================================================
// Module   : even_parity_rx
// Brief    : Serial receiver/checker for even-parity frames, LSB first:
//            start(0), DATA_W data bits, even-parity bit, stop(1).
//            The line is sampled only on bit_en strobes from an upstream
//            baud/sample timer. Each completed frame is delivered with
//            one-cycle parity/framing status pulses.
// Option   : EVEN_PARITY_RX_ERRCNT_EN adds a saturating 8-bit error counter
//            (err_count) with a synchronous clear input (err_clr).
// Revision : 1.0 - initial release
// ============================================================================
module even_parity_rx #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              rx_in,
`ifdef EVEN_PARITY_RX_ERRCNT_EN
  input  logic              err_clr,
  output logic [7:0]        err_count,
`endif
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] shreg_next;
  logic [CNT_W-1:0]  cnt;
  logic              run_par;
  logic              par_bad;

  // New bit enters at the MSB so the first (LSB) data bit lands in bit 0.
  generate
    if (DATA_W == 1) begin : g_shift_one
      assign shreg_next = rx_in;
    end else begin : g_shift_multi
      assign shreg_next = {rx_in, shreg[DATA_W-1:1]};
    end
  endgenerate

  // Frame state machine; all transitions gated by bit_en, status outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      run_par    <= 1'b0;
      par_bad    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (bit_en) begin
        case (state)
          IDLE: begin
            if (!rx_in) begin
              state   <= DATA;
              cnt     <= '0;
              run_par <= 1'b0;
              busy    <= 1'b1;
            end
          end
          DATA: begin
            shreg   <= shreg_next;
            run_par <= run_par ^ rx_in;
            cnt     <= cnt + CNT_W'(1);
            if (cnt == LAST_IDX) begin
              state <= PARITY;
            end
          end
          PARITY: begin
            par_bad <= run_par ^ rx_in;
            state   <= STOP;
          end
          STOP: begin
            // Frame is delivered even when errored; the flags mark it.
            state      <= IDLE;
            busy       <= 1'b0;
            data_valid <= 1'b1;
            data_out   <= shreg;
            parity_err <= par_bad;
            frame_err  <= ~rx_in;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef EVEN_PARITY_RX_ERRCNT_EN
  // Saturating count of errored frames; clear wins over a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= 8'd0;
    end else if (err_clr) begin
      err_count <= 8'd0;
    end else if (bit_en && (state == STOP) && (par_bad || !rx_in)
                 && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_even_parity_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_even_parity_rx
// Brief    : Self-checking bench for even_parity_rx (DATA_W=4) using a
//            table of directed frames plus hand-written corner sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_even_parity_rx;

  localparam int DATA_W = 4;

  logic              clk;
  logic              rst;
  logic              bit_en;
  logic              rx_in;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;
`ifdef EVEN_PARITY_RX_ERRCNT_EN
  logic              err_clr;
  logic [7:0]        err_count;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              perr;
    logic              ferr;
  } cap_t;

  cap_t caps[$];

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              par;
    logic              stop;
    logic [DATA_W-1:0] exp_data;
    logic              exp_perr;
    logic              exp_ferr;
  } vec_t;

  vec_t vecs[8];

  even_parity_rx #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (bit_en),
    .rx_in      (rx_in),
`ifdef EVEN_PARITY_RX_ERRCNT_EN
    .err_clr    (err_clr),
    .err_count  (err_count),
`endif
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: capture completions, check pulse shape and busy during delivery.
  logic prev_dv = 1'b0;
  always @(negedge clk) begin
    if (data_valid === 1'b1) begin
      caps.push_back('{data: data_out, perr: parity_err, ferr: frame_err});
      chk("busy_low_on_valid", {31'd0, busy}, 32'd0);
      chk("valid_single_cycle", {31'd0, prev_dv}, 32'd0);
    end else if (!rst) begin
      chk("flags_zero_outside_valid", {30'd0, parity_err, frame_err}, 32'd0);
    end
    prev_dv = (data_valid === 1'b1);
  end

  // One bit cell: bit_en low for period-1 cycles, then a single strobe.
  task automatic send_bit(input logic b, input int period);
    rx_in  = b;
    bit_en = 1'b0;
    repeat (period - 1) begin
      @(posedge clk);
      #1;
    end
    bit_en = 1'b1;
    @(posedge clk);
    #1;
    bit_en = 1'b0;
  endtask

  task automatic send_frame(input logic [DATA_W-1:0] d, input logic p, input logic s,
                            input int period);
    send_bit(1'b0, period);
    for (int i = 0; i < DATA_W; i++) send_bit(d[i], period);
    send_bit(p, period);
    send_bit(s, period);
  endtask

  initial begin
    int n;
    vecs[0] = '{4'b0111, 1'b1, 1'b1, 4'b0111, 1'b0, 1'b0};
    vecs[1] = '{4'b0011, 1'b1, 1'b1, 4'b0011, 1'b1, 1'b0};
    vecs[2] = '{4'b0000, 1'b0, 1'b1, 4'b0000, 1'b0, 1'b0};
    vecs[3] = '{4'b1111, 1'b0, 1'b0, 4'b1111, 1'b0, 1'b1};
    vecs[4] = '{4'b1010, 1'b1, 1'b1, 4'b1010, 1'b1, 1'b0};
    vecs[5] = '{4'b1101, 1'b1, 1'b1, 4'b1101, 1'b0, 1'b0};
    vecs[6] = '{4'b0110, 1'b1, 1'b0, 4'b0110, 1'b1, 1'b1};
    vecs[7] = '{4'b1011, 1'b1, 1'b1, 4'b1011, 1'b0, 1'b0};

    rst    = 1'b1;
    bit_en = 1'b0;
    rx_in  = 1'b1;
`ifdef EVEN_PARITY_RX_ERRCNT_EN
    err_clr = 1'b0;
`endif

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_data_out", {28'd0, data_out}, 32'd0);
    chk("reset_flags", {28'd0, data_valid, parity_err, frame_err, busy}, 32'd0);
`ifdef EVEN_PARITY_RX_ERRCNT_EN
    chk("reset_err_count", {24'd0, err_count}, 32'd0);
`endif
    rst = 1'b0;

    // Idle line for 40 cycles: no frame, never busy
    for (int i = 0; i < 10; i++) begin
      send_bit(1'b1, 4);
      chk("idle_busy", {31'd0, busy}, 32'd0);
    end
    chk("idle_no_valid", caps.size(), 32'd0);

    // Table of frames, bit_en every 4th cycle
    for (int v = 0; v < 8; v++) begin
      n = caps.size();
      send_frame(vecs[v].data, vecs[v].par, vecs[v].stop, 4);
      chk("latency_valid", {31'd0, data_valid}, 32'd1);
      chk("latency_data", {28'd0, data_out}, {28'd0, vecs[v].exp_data});
      @(posedge clk);
      #1;
      chk("valid_dropped", {31'd0, data_valid}, 32'd0);
      chk("one_capture", caps.size(), n + 1);
      if (caps.size() == n + 1) begin
        chk("cap_data", {28'd0, caps[n].data}, {28'd0, vecs[v].exp_data});
        chk("cap_parity_err", {31'd0, caps[n].perr}, {31'd0, vecs[v].exp_perr});
        chk("cap_frame_err", {31'd0, caps[n].ferr}, {31'd0, vecs[v].exp_ferr});
      end
      repeat (6) @(posedge clk);
      #1;
      chk("data_held", {28'd0, data_out}, {28'd0, vecs[v].exp_data});
      chk("idle_after_frame", {31'd0, busy}, 32'd0);
    end

    // Back-to-back frames with bit_en every cycle
    n = caps.size();
    send_frame(4'b0001, 1'b1, 1'b1, 1);
    send_frame(4'b1000, 1'b1, 1'b1, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_count", caps.size(), n + 2);
    if (caps.size() == n + 2) begin
      chk("b2b_first", {26'd0, caps[n].data, caps[n].perr, caps[n].ferr}, {26'd0, 4'b0001, 2'b00});
      chk("b2b_second", {26'd0, caps[n+1].data, caps[n+1].perr, caps[n+1].ferr}, {26'd0, 4'b1000, 2'b00});
    end

    // Mid-frame reset after two data bits
    n = caps.size();
    send_bit(1'b0, 4);
    send_bit(1'b1, 4);
    send_bit(1'b0, 4);
    chk("midframe_busy", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_busy", {31'd0, busy}, 32'd0);
    chk("async_reset_data", {28'd0, data_out}, 32'd0);
    rx_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) send_bit(1'b1, 4);
    chk("abort_no_valid", caps.size(), n);
    chk("abort_idle", {31'd0, busy}, 32'd0);
    send_frame(4'b0101, 1'b0, 1'b1, 4);
    chk("post_reset_valid", {31'd0, data_valid}, 32'd1);
    chk("post_reset_data", {28'd0, data_out}, {28'd0, 4'b0101});
    chk("post_reset_flags", {30'd0, parity_err, frame_err}, 32'd0);
    @(posedge clk);
    #1;

`ifdef EVEN_PARITY_RX_ERRCNT_EN
    chk("errcnt_after_reset", {24'd0, err_count}, 32'd0);
    for (int i = 0; i < 3; i++) send_frame(4'b0011, 1'b1, 1'b1, 4);
    @(posedge clk);
    #1;
    chk("errcnt_three", {24'd0, err_count}, 32'd3);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    chk("errcnt_cleared", {24'd0, err_count}, 32'd0);
    for (int i = 0; i < 300; i++) send_frame(4'b0110, 1'b1, 1'b0, 1);
    @(posedge clk);
    #1;
    chk("errcnt_saturate", {24'd0, err_count}, 32'd255);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
